csa_accum_ctrl: RTL and testbench
=================================

Name: csa_accum_ctrl

Overview:
- Sequencing controller that accumulates a run-time count of BIT_LEN-bit operands through one shared carry_save_adder instance.
- Keeps the running total in redundant (sum, carry) form, one operand per accepted beat.
- Resolves the total to binary by iterating the same CSA with its third input forced to zero.
- Sits in front of the BLS12_381 limb datapaths as a multi-operand column accumulator, with a valid/ready handshake on both input and output.

Parameters:
- BIT_LEN, 19, operand width in bits.
- MAX_OPS, 8, maximum operands per accumulation (must be ≥1).
- CNT_W (localparam), $clog2(MAX_OPS+1), width of the operand counter.
- OUT_LEN (localparam), BIT_LEN+$clog2(MAX_OPS), result width; MAX_OPS=1 gives OUT_LEN=BIT_LEN.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse to begin an accumulation; honoured only in IDLE.
- num_ops  input  CNT_W  operand count, sampled with start; must be ≤ MAX_OPS.
- op_valid  input  1  operand beat valid.
- op_data  input  BIT_LEN  operand, zero-extended to OUT_LEN.
- op_ready  output  1  controller accepts an operand this cycle.
- res_valid  output  1  result available.
- res_data  output  OUT_LEN  binary sum of the operands, modulo 2^OUT_LEN.
- res_ready  input  1  consumer takes the result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; sum_q, carry_q and cnt_q cleared.
  - op_ready=0, res_valid=0, res_data=0, busy=0.
  - Reset mid-operation abandons the run; the partial result is discarded.
- Registers:
  - sum_q and carry_q are OUT_LEN bits each.
  - carry_q is stored pre-shifted: carry_q <= {Cout[OUT_LEN-2:0],1'b0}, so the MSB carry is dropped (modulo behaviour).
- Shared CSA, BIT_LEN=OUT_LEN, fully combinational:
  - A=sum_q, B=carry_q.
  - Cin = zero-extended op_data in ACCUM, 0 in RESOLVE.
- IDLE:
  - op_ready=0, res_valid=0.
  - start with num_ops≥1: clear sum_q/carry_q, cnt_q<=num_ops, go to ACCUM.
  - start with num_ops==0: clear sum_q/carry_q, go directly to DONE; the result is 0.
- ACCUM:
  - op_ready=1 combinationally.
  - On op_valid&&op_ready: sum_q<=S, carry_q<=Cout<<1, cnt_q<=cnt_q-1.
  - On the beat where cnt_q==1, go to RESOLVE.
  - No accept means no state change; gaps in op_valid are allowed.
- RESOLVE:
  - If carry_q==0, go to DONE this cycle; sum_q is final and no CSA update occurs.
  - Otherwise sum_q<=S (=sum_q^carry_q) and carry_q<=Cout<<1 (=(sum_q&carry_q)<<1), then stay.
  - Takes at most OUT_LEN cycles. An assertion flags an overrun.
- DONE:
  - res_valid=1; res_data=sum_q, held stable until the handshake.
  - On res_ready: go to IDLE; res_valid drops the next cycle.
- Latency: from the last accepted operand, 1 to OUT_LEN+1 cycles to res_valid, depending on the carry chain length.
- start outside IDLE is ignored, including start coincident with a res_ready handshake in DONE.
- num_ops > MAX_OPS is illegal: assertion error; behaviour undefined beyond modulo wrap.
- res_data reads 0 outside DONE.

Decomposition:
- Package csa_ctrl_pkg:
  - state enum {IDLE, ACCUM, RESOLVE, DONE}.
  - Width helper functions used for CNT_W and OUT_LEN.
- Sub-module: one existing carry_save_adder instance, parameterised to OUT_LEN.
- The state machine, counter and operand mux stay in csa_accum_ctrl.

Test Plan (BIT_LEN=19, MAX_OPS=8, so OUT_LEN=22):
- Hold rst_n=0, drive random inputs -> op_ready=0, res_valid=0, res_data=0, busy=0. Release reset -> state IDLE, busy=0.
- start, num_ops=3; operands 5, 7, 9 back-to-back -> op_ready high 3 cycles; res_valid with res_data=21 (0x000015); output held while res_ready=0 for 5 cycles, then clears.
- start, num_ops=8; eight operands of 0x7FFFF, with op_valid gapped every other cycle -> res_data=0x3FFFF8. A start pulse mid-ACCUM is ignored and the result is unchanged.
- start, num_ops=2; operands 0x7FFFF and 0x00001 (long ripple) -> res_data=0x080000. RESOLVE lasts ≤22 cycles and the assertion does not fire.
- start, num_ops=0 -> DONE one cycle later, res_data=0, op_ready never asserted.
- num_ops=4 accumulation; assert rst_n=0 during RESOLVE -> all outputs drop to reset values immediately. A fresh run of operands 1, 2, 3, 4 afterwards -> res_data=10.

Source files
------------

// File: rtl/csa_ctrl_pkg.sv
// Shared types and width helpers for the carry-save column accumulator.
// Imported by the controller top level.
package csa_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    DONE
  } state_e;

  function automatic int cnt_width(input int max_ops);
    return $clog2(max_ops + 1);
  endfunction

  function automatic int out_width(input int bit_len, input int max_ops);
    return bit_len + $clog2(max_ops);
  endfunction

endpackage

// File: rtl/carry_save_adder.sv
// Combinational 3:2 carry-save adder: per-bit full adders with no carry propagation.
// Cout is returned unshifted; the caller aligns it.
module carry_save_adder #(
  parameter int BIT_LEN = 19
) (
  input  logic [BIT_LEN-1:0] a,
  input  logic [BIT_LEN-1:0] b,
  input  logic [BIT_LEN-1:0] cin,
  output logic [BIT_LEN-1:0] s,
  output logic [BIT_LEN-1:0] cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator: sums operands in redundant (sum, carry) form through one CSA,
// then resolves to binary by re-running the same CSA with its third input at zero.
module csa_accum_ctrl
  import csa_ctrl_pkg::*;
#(
  parameter  int BIT_LEN = 19,
  parameter  int MAX_OPS = 8,
  localparam int CNT_W   = cnt_width(MAX_OPS),
  localparam int OUT_LEN = out_width(BIT_LEN, MAX_OPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_ops,
  input  logic               op_valid,
  input  logic [BIT_LEN-1:0] op_data,
  output logic               op_ready,
  output logic               res_valid,
  output logic [OUT_LEN-1:0] res_data,
  input  logic               res_ready,
  output logic               busy
);

  localparam int RES_W = $clog2(OUT_LEN + 1);

  state_e             state;
  logic [OUT_LEN-1:0] sum_q;
  logic [OUT_LEN-1:0] carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [RES_W-1:0]   res_cyc_q;

  logic [OUT_LEN-1:0] csa_cin;
  logic [OUT_LEN-1:0] csa_s;
  logic [OUT_LEN-1:0] csa_cout;
  logic               accept;

  assign accept  = op_valid && (state == ACCUM);
  assign csa_cin = (state == ACCUM) ? OUT_LEN'(op_data) : '0;

  carry_save_adder #(
    .BIT_LEN(OUT_LEN)
  ) u_csa (
    .a   (sum_q),
    .b   (carry_q),
    .cin (csa_cin),
    .s   (csa_s),
    .cout(csa_cout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sum_q     <= '0;
      carry_q   <= '0;
      cnt_q     <= '0;
      res_cyc_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= num_ops;
            state   <= (num_ops == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            sum_q   <= csa_s;
            // Shift left by one drops the top carry: the total wraps modulo 2^OUT_LEN.
            carry_q <= csa_cout << 1;
            cnt_q   <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state <= RESOLVE;
          end
        end
        RESOLVE: begin
          if (carry_q == '0) begin
            state     <= DONE;
            res_cyc_q <= '0;
          end else begin
            sum_q     <= csa_s;
            carry_q   <= csa_cout << 1;
            res_cyc_q <= res_cyc_q + RES_W'(1);
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign op_ready  = (state == ACCUM);
  assign res_valid = (state == DONE);
  assign res_data  = (state == DONE) ? sum_q : '0;
  assign busy      = (state != IDLE);

  // Each resolve step moves the lowest carry bit up by at least one position.
  a_resolve_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (state == RESOLVE) |-> (res_cyc_q < RES_W'(OUT_LEN)));

  a_num_ops_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (state == IDLE && start) |-> (num_ops <= CNT_W'(MAX_OPS)));

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Scoreboard bench for csa_accum_ctrl: stimulus pushes expected sums, a monitor pops
// and compares whenever a result is presented.
module tb_csa_accum_ctrl;

  localparam int BL = 19;
  localparam int MO = 8;
  localparam int CW = 4;
  localparam int OL = 22;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_ops = '0;
  logic          op_valid = 1'b0;
  logic [BL-1:0] op_data = '0;
  logic          op_ready;
  logic          res_valid;
  logic [OL-1:0] res_data;
  logic          res_ready = 1'b0;
  logic          busy;

  int            checks = 0;
  int            failures = 0;
  int            op_ready_cnt = 0;
  logic [OL-1:0] exp_q[$];

  csa_accum_ctrl #(
    .BIT_LEN(BL),
    .MAX_OPS(MO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .num_ops  (num_ops),
    .op_valid (op_valid),
    .op_data  (op_data),
    .op_ready (op_ready),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_ready(res_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer sum of the operands, wrapped to the result width.
  function automatic logic [OL-1:0] ref_sum(input logic [BL-1:0] ops[$]);
    longint unsigned acc = 0;
    foreach (ops[i]) acc += longint'(ops[i]);
    return OL'(acc % (64'd1 << OL));
  endfunction

  // Monitor: compares every presented result against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && op_ready) op_ready_cnt++;
      if (rst_n && res_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=0x%0h required=none", res_data);
        end else if (res_ready) begin
          check("result", 64'(res_data), 64'(exp_q.pop_front()));
        end else begin
          check("result_held", 64'(res_data), 64'(exp_q[0]));
        end
      end
    end
  end

  task automatic do_start(input int n);
    start   = 1'b1;
    num_ops = CW'(n);
    tick();
    start   = 1'b0;
    num_ops = CW'($urandom_range(0, MO));
  endtask

  task automatic send_ops(input logic [BL-1:0] ops[$], input int gap, input bit mid_start);
    foreach (ops[i]) begin
      int g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      int t = 0;
      for (int k = 0; k < g; k++) begin
        op_valid = 1'b0;
        op_data  = BL'($urandom);
        if (mid_start && i == 2 && k == 0) begin
          start   = 1'b1;
          num_ops = CW'(2);
        end
        tick();
        start = 1'b0;
      end
      op_valid = 1'b1;
      op_data  = ops[i];
      while (!op_ready && t < 20) begin
        tick();
        t++;
      end
      if (t == 20) check("op_ready_timeout", 64'(t), 64'(0));
      tick();
      op_valid = 1'b0;
    end
  endtask

  task automatic wait_result(input int n, input int hold);
    int lat = 0;
    while (!res_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (n > 0) check("latency_in_range", 64'(lat >= 1 && lat <= OL + 1), 64'(1));
    else       check("zero_ops_latency", 64'(lat), 64'(0));
    res_ready = 1'b0;
    repeat (hold) tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("valid_clears", 64'({res_valid, busy}), 64'(0));
    check("data_clears", 64'(res_data), 64'(0));
  endtask

  task automatic run_acc(input logic [BL-1:0] ops[$], input int gap, input bit mid_start,
                         input int hold);
    exp_q.push_back(ref_sum(ops));
    do_start(ops.size());
    send_ops(ops, gap, mid_start);
    wait_result(ops.size(), hold);
  endtask

  initial begin
    logic [BL-1:0] ops[$];

    // Reset held with random inputs: all outputs must stay at reset values.
    for (int i = 0; i < 4; i++) begin
      start     = 1'($urandom);
      num_ops   = CW'($urandom_range(0, MO));
      op_valid  = 1'($urandom);
      op_data   = BL'($urandom);
      res_ready = 1'($urandom);
      tick();
      check("reset_outputs", 64'({op_ready, res_valid, busy}), 64'(0));
      check("reset_data", 64'(res_data), 64'(0));
    end
    start = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", 64'({op_ready, res_valid, busy}), 64'(0));

    // Three back-to-back operands, result held for five cycles.
    op_ready_cnt = 0;
    ops = {19'd5, 19'd7, 19'd9};
    run_acc(ops, 0, 1'b0, 5);
    check("op_ready_cycles_3", 64'(op_ready_cnt), 64'(3));

    // Eight max-value operands with gaps; a start pulse mid-run must be ignored.
    ops = {};
    for (int i = 0; i < 8; i++) ops.push_back(19'h7FFFF);
    check("model_all_ones", 64'(ref_sum(ops)), 64'(22'h3FFFF8));
    run_acc(ops, 1, 1'b1, 1);

    // Long ripple through the resolve phase.
    ops = {19'h7FFFF, 19'h00001};
    run_acc(ops, 0, 1'b0, 0);

    // Zero operands: straight to DONE with a zero result, op_ready never raised.
    op_ready_cnt = 0;
    exp_q.push_back('0);
    do_start(0);
    check("zero_ops_done", 64'({res_valid, busy}), 64'(2'b11));
    wait_result(0, 1);
    check("zero_ops_no_ready", 64'(op_ready_cnt), 64'(0));

    // Reset during RESOLVE abandons the run.
    ops = {19'h7FFFF, 19'h00001, 19'h0, 19'h0};
    exp_q.push_back(ref_sum(ops));
    do_start(4);
    send_ops(ops, 0, 1'b0);
    check("in_resolve", 64'({busy, op_ready, res_valid}), 64'(3'b100));
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrun_reset_outputs", 64'({op_ready, res_valid, busy}), 64'(0));
    check("midrun_reset_data", 64'(res_data), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    ops = {19'd1, 19'd2, 19'd3, 19'd4};
    run_acc(ops, 0, 1'b0, 2);

    // Randomised runs with random gaps and back-pressure.
    for (int r = 0; r < 10; r++) begin
      int n = $urandom_range(1, MO);
      ops = {};
      for (int i = 0; i < n; i++) ops.push_back(BL'($urandom));
      run_acc(ops, -1, 1'b0, $urandom_range(0, 3));
    end

    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
